// File: rtl/arb_pkg.sv
// arb_pkg
//   Shared types and helpers for the round-robin enum arbiter slice.
//   - arb_state_t : controller state encoding (2-bit, fixed values so the
//                   encoding stays stable across tools and waveforms)
//   - MAX_REQ     : widest requester vector the arbiter supports
//   - onehot()    : index -> one-hot vector, MAX_REQ bits wide; callers
//                   size-cast the result down to their own width
package arb_pkg;

  localparam int MAX_REQ = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  // Bits at or above n are never set, so an out-of-range index gives zero
  // rather than a stray grant.
  function automatic logic [MAX_REQ-1:0] onehot(input int idx, input int n);
    logic [MAX_REQ-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if ((i == idx) && (i < n)) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Purely combinational wrap-around priority search. Returns the first
//   set bit of req at or above ptr, wrapping to bit 0 when nothing at or
//   above ptr is set.
//   Ports:
//     req    [N_REQ-1:0] in  : request levels
//     ptr    [IW-1:0]    in  : search start index
//     any                out : at least one request is set
//     winner [IW-1:0]    out : selected index (0 when any=0)
module rr_pick
  import arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             any,
  output logic [IW-1:0]    winner
);

  logic          hi_any;
  logic [IW-1:0] hi_idx;
  logic [IW-1:0] lo_idx;

  // Scan downward so the lowest qualifying index is the last one written.
  // hi_* tracks the lowest set bit at or above ptr; lo_idx tracks the
  // lowest set bit overall, which is the wrap-around candidate.
  always_comb begin
    hi_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_idx = IW'(j);
        if (j >= int'(ptr)) begin
          hi_any = 1'b1;
          hi_idx = IW'(j);
        end
      end
    end
  end

  assign any    = |req;
  assign winner = hi_any ? hi_idx : lo_idx;

endmodule

// File: rtl/rr_enum_arbiter.sv
// rr_enum_arbiter
//   Round-robin owner selection for a shared enum-state sequential block.
//   Grants exclusive ownership, revokes after MAX_HOLD cycles and forces a
//   one-cycle idle gap between owners.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no owner; arbitrate on any request, grant on this edge
//   ST_BUSY | one owner; watch its req and the hold limit, ignore others
//   ST_GAP  | owner just left; one dead cycle, requests not sampled
//
//   Ports:
//     clk                  in  : clock, rising edge
//     rst                  in  : asynchronous active-high reset
//     req      [N_REQ-1:0] in  : per-requester request level
//     grant    [N_REQ-1:0] out : registered one-hot ownership, 0 = none
//     grant_id [IW-1:0]    out : owner index, valid while busy
//     busy                 out : grant is non-zero
//     timeout              out : one-cycle pulse on a MAX_HOLD revocation
module rr_enum_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8,
  parameter int IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_id,
  output logic             busy,
  output logic             timeout
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] ID_LAST   = IW'(N_REQ - 1);

  arb_state_t     state;
  logic [IW-1:0]  ptr;
  logic [HW-1:0]  hold_cnt;

  logic           pick_any;
  logic [IW-1:0]  pick_winner;
  logic [N_REQ-1:0] win_grant;
  logic           owner_req;
  logic           at_limit;
  logic [IW-1:0]  next_ptr;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .any    (pick_any),
    .winner (pick_winner)
  );

  assign win_grant = N_REQ'(onehot(int'(pick_winner), N_REQ));

  // grant is one-hot on the owner, so masking req with it reads the
  // owner's request bit without an index that may be out of range.
  assign owner_req = |(req & grant);
  assign at_limit  = (hold_cnt == HOLD_LAST);

  // With N_REQ=1 the owner is always ID_LAST, so ptr stays at 0.
  assign next_ptr = (grant_id == ID_LAST) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant    <= win_grant;
            grant_id <= pick_winner;
            busy     <= 1'b1;
            hold_cnt <= '0;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A release on the limit cycle counts as a release, not a timeout.
          if (!owner_req || at_limit) begin
            grant   <= '0;
            busy    <= 1'b0;
            ptr     <= next_ptr;
            timeout <= owner_req;
            state   <= ST_GAP;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_enum_arbiter.sv
module tb_rr_enum_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req4;
  logic [3:0] grant4;
  logic [1:0] gid4;
  logic       busy4;
  logic       to4;
  logic [0:0] req1;
  logic [0:0] grant1;
  logic [0:0] gid1;
  logic       busy1;
  logic       to1;

  int passed = 0;
  int total  = 0;

  rr_enum_arbiter #(.N_REQ(4), .MAX_HOLD(3)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .req      (req4),
    .grant    (grant4),
    .grant_id (gid4),
    .busy     (busy4),
    .timeout  (to4)
  );

  rr_enum_arbiter #(.N_REQ(1), .MAX_HOLD(2)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .req      (req1),
    .grant    (grant1),
    .grant_id (gid1),
    .busy     (busy1),
    .timeout  (to1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, landing on the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] g, input logic [1:0] id,
                      input logic b, input logic t);
    chk({tag, ".grant"},   32'(grant4), 32'(g));
    if (g != 4'b0000) chk({tag, ".grant_id"}, 32'(gid4), 32'(id));
    chk({tag, ".busy"},    32'(busy4),  32'(b));
    chk({tag, ".timeout"}, 32'(to4),    32'(t));
  endtask

  initial begin
    logic [3:0] exp_g;
    rst  = 1'b1;
    req4 = 4'b0000;
    req1 = 1'b0;
    cyc();
    cyc();
    chk4("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    chk("reset.grant_id", 32'(gid4), 32'd0);
    chk("reset.n1_grant", 32'(grant1), 32'd0);

    // Reset mid-grant
    rst  = 1'b0;
    req4 = 4'b0010;
    cyc();
    chk4("midrst.granted", 4'b0010, 2'd1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst.async_grant", 32'(grant4), 32'd0);
    chk("midrst.async_busy",  32'(busy4),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    chk4("midrst.regrant", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Fresh start for round-robin so ptr is 0
    rst = 1'b1;
    cyc();
    rst  = 1'b0;
    req4 = 4'b1111;
    cyc();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      for (int c = 0; c < 3; c++) begin
        chk4("rr.hold", exp_g, 2'(k % 4), 1'b1, 1'b0);
        cyc();
      end
      chk4("rr.gap", 4'b0000, 2'd0, 1'b0, 1'b1);
      cyc();
      chk4("rr.idle", 4'b0000, 2'd0, 1'b0, 1'b0);
      cyc();
    end
    chk4("rr.owner1_again", 4'b0010, 2'd1, 1'b1, 1'b0);
    req4 = 4'b0000;
    cyc();
    cyc();

    // Release before timeout; ptr now 2
    req4 = 4'b0100;
    cyc();
    chk4("rel.granted", 4'b0100, 2'd2, 1'b1, 1'b0);
    cyc();
    chk4("rel.held", 4'b0100, 2'd2, 1'b1, 1'b0);
    req4 = 4'b0101;
    req4[2] = 1'b0;
    cyc();
    chk4("rel.dropped", 4'b0000, 2'd0, 1'b0, 1'b0);
    req4 = 4'b0101;
    cyc();
    chk4("rel.idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc();
    chk4("rel.wrap_to_0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Release on the same edge the hold limit is reached
    cyc();
    cyc();
    chk4("lim.last_cycle", 4'b0001, 2'd0, 1'b1, 1'b0);
    req4 = 4'b0100;
    cyc();
    chk4("lim.release_wins", 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc();
    cyc();
    chk4("lim.next_owner", 4'b0100, 2'd2, 1'b1, 1'b0);
    req4 = 4'b0000;
    cyc();
    cyc();

    // Late requester ignored while busy; ptr now 3
    req4 = 4'b0001;
    cyc();
    chk4("late.owner0", 4'b0001, 2'd0, 1'b1, 1'b0);
    req4 = 4'b1001;
    cyc();
    chk4("late.still0", 4'b0001, 2'd0, 1'b1, 1'b0);
    req4 = 4'b1000;
    cyc();
    chk4("late.gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc();
    chk4("late.idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc();
    chk4("late.owner3", 4'b1000, 2'd3, 1'b1, 1'b0);
    req4 = 4'b0000;

    // Single requester, MAX_HOLD=2: grant 1,1,0,0 repeating
    req1 = 1'b1;
    cyc();
    for (int p = 0; p < 12; p++) begin
      chk("n1.grant",    32'(grant1), 32'((p % 4) < 2));
      chk("n1.busy",     32'(busy1),  32'((p % 4) < 2));
      chk("n1.grant_id", 32'(gid1),   32'd0);
      chk("n1.timeout",  32'(to1),    32'((p % 4) == 2));
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rr_enum_arbiter.md
# rr_enum_arbiter

Round-robin arbiter that shares one enum-state sequential resource among `N_REQ` requesters. It grants exclusive ownership, enforces a maximum hold time, and inserts a mandatory idle gap between owners. It sits in front of the shared state-machine block and drives its select/enable, so that block's enumerated state is only advanced by one owner at a time. The controller is itself an enumerated-state FSM.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters; legal values 1..16.
- `MAX_HOLD`, 8: maximum consecutive grant cycles per ownership; legal values 2..255.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset; **asynchronous, active-high**.
- `req`, input, `N_REQ`: per-requester request level; requester holds it high while it wants or owns the resource.
- `grant`, output, `N_REQ`: registered one-hot ownership; all-zero when no owner.
- `grant_id`, output, `$clog2(N_REQ)` (min 1): index of the current owner; valid only while `busy`=1.
- `busy`, output, 1: high exactly when `grant` is non-zero.
- `timeout`, output, 1: one-cycle pulse when an ownership is revoked by `MAX_HOLD`.

## Operation
- States (enum `arb_state_t`): `ST_IDLE`, `ST_BUSY`, `ST_GAP`.
- `ST_IDLE`: if `req` is non-zero, select the winner as the first set bit at or after `ptr`, searching upward with modulo-`N_REQ` wrap. Set `grant` to onehot(winner), `grant_id` to winner, `busy` to 1 and `hold_cnt` to 0, then go to `ST_BUSY`. If `req` is zero, stay in `ST_IDLE`.
- `ST_BUSY`, checked each cycle:
  - If `req[grant_id]` is 0 (release), clear `grant` and `busy`, set `ptr` to (`grant_id`+1) mod `N_REQ`, and go to `ST_GAP`.
  - Otherwise, if `hold_cnt` equals `MAX_HOLD`-1, revoke the grant with the same actions as a release, and also pulse `timeout` for 1 cycle.
  - Otherwise, increment `hold_cnt`.
  - Changes on other requesters' `req` bits are ignored while in `ST_BUSY`.
- `ST_GAP`: exactly one cycle with no owner, then go to `ST_IDLE`. Requests are not sampled in this state.
- `hold_cnt` is `$clog2(MAX_HOLD+1)` bits wide and never wraps; it is reset to 0 on each new grant.
- Pointer wrap: `ptr`=`N_REQ`-1 plus a release gives `ptr`=0. With `N_REQ`=1, `ptr` is constantly 0.
- Release and timeout in the same cycle: release wins and `timeout` stays 0.
- A revoked requester that keeps `req` high is re-queued normally. It wins again only after every other active requester has had a turn.

## Timing
- Reset values: state `ST_IDLE`, `grant`=0, `grant_id`=0, `busy`=0, `timeout`=0, `ptr`=0, `hold_cnt`=0.
- Asserting `rst` clears everything immediately, without waiting for a clock edge, even mid-ownership. After `rst` deasserts, the first arbitration happens on the first rising edge.
- Grant latency: `req` seen high at edge k while in `ST_IDLE` gives `grant` high after edge k. That is one cycle from `req` rising when the request is set up before edge k.
- Maximum ownership: `grant` is high for at most `MAX_HOLD` cycles.
- Release latency: `req` of the owner is low at edge k, so `grant` is low after edge k.
- Minimum spacing between owners is 1 cycle at `ST_GAP` plus 1 cycle at `ST_IDLE`. The next `grant` appears 2 edges after the previous `grant` falls.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package `arb_pkg` holds:
  - `arb_state_t` (3-value enum, explicit 2-bit encoding `ST_IDLE`=0, `ST_BUSY`=1, `ST_GAP`=2);
  - function `onehot(idx, n)`.
- Sub-module `rr_pick`: purely combinational. Inputs are `req` and `ptr`; outputs are `any` and `winner` index. This is the wrap-around priority search, instantiated once.
- The top module contains the FSM, `ptr`, `hold_cnt` and the output registers.

## Test plan
- Reset mid-grant: `N_REQ`=4, `req`=0010, owner 1. Assert `rst` between clock edges → `grant`=0000, `busy`=0 before the next edge. After release, `req`=0010 → `grant`=0010 after 1 edge.
- Round-robin: `req`=1111 held, `MAX_HOLD`=3 → owners 0,1,2,3,0 in order. Each owner has `grant` high for 3 cycles, then 2 cycles with no owner. `timeout` pulses once per owner.
- Release before timeout: owner 2 holds `req` for 2 cycles then drops it → `grant` falls. `ptr`=3, so with `req`=0101 the next owner is 0 (wrap), and `timeout` stays 0.
- Simultaneous release and limit: owner drops `req` on the same edge where `hold_cnt`=`MAX_HOLD`-1 → `grant` clears and `timeout`=0.
- Late requester ignored while busy: owner 0 is active and `req[3]` rises → `grant` stays 0001. Only after `ST_GAP` and `ST_IDLE` does `grant` become 1000.
- `N_REQ`=1: `req`=1 held, `MAX_HOLD`=2 → `grant` pattern 1,1,0,0 repeating, with `grant_id`=0 and a `timeout` pulse every 4 cycles.
